// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: transfer types, responses,
// slave selects and the error-responder state.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_0    = 3'b001;
  localparam logic [2:0] SEL_1    = 3'b010;
  localparam logic [2:0] SEL_2    = 3'b100;

  typedef enum logic [1:0] {
    ERR_OKAY = 2'b00,
    ERR_ERR1 = 2'b01,
    ERR_ERR2 = 2'b10
  } err_state_t;

  // NONSEQ and SEQ are the only transfer types that move data.
  function automatic logic is_transfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational decode of an AHB address into three contiguous APB slave
// regions starting at BASE_ADDR, each SLV_SIZE bytes.
module ahb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0100_0000
) (
  input  logic [31:0] addr,
  output logic        mapped,
  output logic [2:0]  sel
);

  // 34-bit arithmetic so the window end cannot wrap for large regions.
  localparam logic [33:0] SZ1 = {2'b00, SLV_SIZE};
  localparam logic [33:0] SZ2 = SZ1 << 1;
  localparam logic [33:0] SZ3 = SZ1 + SZ2;

  logic [33:0] off;
  assign off = {2'b00, addr} - {2'b00, BASE_ADDR};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sel = SEL_NONE;
    if (addr >= BASE_ADDR) begin
      if (off < SZ1)      sel = SEL_0;
      else if (off < SZ2) sel = SEL_1;
      else if (off < SZ3) sel = SEL_2;
    end
  end

  assign mapped = (sel != SEL_NONE);

endmodule

// File: rtl/ahb_slave_frontend.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification,
// address/data pipeline, slave decode and a two-cycle ERROR responder.
module ahb_slave_frontend
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0100_0000,
  parameter int          ERRCNT_W  = 8
) (
  input  logic                Hclk,
  input  logic                Hreset,
  input  logic                Hwrite,
  input  logic                Hreadyin,
  input  logic [1:0]          Htrans,
  input  logic [31:0]         Haddr,
  input  logic [31:0]         Hwdata,
  input  logic [31:0]         Prdata,
  input  logic                Hreadyout_apb,
  output logic                valid,
  output logic [31:0]         Haddr1,
  output logic [31:0]         Haddr2,
  output logic [31:0]         Hwdata1,
  output logic [31:0]         Hwdata2,
  output logic                Hwritereg,
  output logic [2:0]          tempselx,
  output logic [31:0]         Hrdata,
  output logic [1:0]          Hresp,
  output logic                Hreadyout,
  output logic [ERRCNT_W-1:0] err_count
);

  err_state_t state, state_next;
  logic       mapped;
  logic       active;

  ahb_addr_decoder #(
    .BASE_ADDR (BASE_ADDR),
    .SLV_SIZE  (SLV_SIZE)
  ) u_decoder (
    .addr   (Haddr),
    .mapped (mapped),
    .sel    (tempselx)
  );

  assign active = Hreadyin && is_transfer(Htrans);
  // Combinational so the controller can accept the transfer in the same cycle.
  assign valid  = active && mapped && (state == ERR_OKAY);
  assign Hrdata = Prdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state     <= ERR_OKAY;
      err_count <= '0;
    end else begin
      state <= state_next;
      if (state == ERR_OKAY && state_next == ERR_ERR1 && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    Hresp      = HRESP_OKAY;
    Hreadyout  = Hreadyout_apb;
    unique case (state)
      ERR_OKAY: begin
        if (active && !mapped) state_next = ERR_ERR1;
      end
      // First ERROR cycle stalls the master so it can cancel the next transfer.
      ERR_ERR1: begin
        Hresp      = HRESP_ERROR;
        Hreadyout  = 1'b0;
        state_next = ERR_ERR2;
      end
      ERR_ERR2: begin
        Hresp      = HRESP_ERROR;
        Hreadyout  = 1'b1;
        state_next = ERR_OKAY;
      end
      default: state_next = ERR_OKAY;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_frontend.sv
// Directed self-checking bench for ahb_slave_frontend.
module tb_ahb_slave_frontend;
  import ahb_apb_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset, Hwrite, Hreadyin, Hreadyout_apb;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        valid, Hwritereg, Hreadyout;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 Hclk = ~Hclk;

  ahb_slave_frontend dut (
    .Hclk          (Hclk),
    .Hreset        (Hreset),
    .Hwrite        (Hwrite),
    .Hreadyin      (Hreadyin),
    .Htrans        (Htrans),
    .Haddr         (Haddr),
    .Hwdata        (Hwdata),
    .Prdata        (Prdata),
    .Hreadyout_apb (Hreadyout_apb),
    .valid         (valid),
    .Haddr1        (Haddr1),
    .Haddr2        (Haddr2),
    .Hwdata1       (Hwdata1),
    .Hwdata2       (Hwdata2),
    .Hwritereg     (Hwritereg),
    .tempselx      (tempselx),
    .Hrdata        (Hrdata),
    .Hresp         (Hresp),
    .Hreadyout     (Hreadyout),
    .err_count     (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 unit after the edge; combinational checks 1 unit later.
  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Hreadyout_apb = 1'b1;
    Htrans = HTRANS_IDLE; Haddr = '0; Hwdata = '0; Prdata = '0;
    tick(); tick();
    Hreset = 1'b0;
    settle();
    check("rst_haddr1", Haddr1, 32'h0);
    check("rst_hresp", 32'(Hresp), 32'h0);
    check("rst_errcnt", 32'(err_count), 32'h0);
    check("rst_hreadyout", 32'(Hreadyout), 32'h1);

    // Mapped NONSEQ write, region 0
    Htrans = HTRANS_NONSEQ; Haddr = 32'h8000_0010; Hwrite = 1'b1;
    settle();
    check("wr_valid", 32'(valid), 32'h1);
    check("wr_sel", 32'(tempselx), 32'h1);
    tick();
    check("wr_haddr1", Haddr1, 32'h8000_0010);
    check("wr_hwritereg", 32'(Hwritereg), 32'h1);

    // SEQ read, region 2, with data phase of the write
    Htrans = HTRANS_SEQ; Haddr = 32'h8200_0004; Hwrite = 1'b0;
    Hwdata = 32'h1111_2222; Prdata = 32'hDEAD_BEEF;
    settle();
    check("rd_valid", 32'(valid), 32'h1);
    check("rd_sel", 32'(tempselx), 32'h4);
    check("rd_hrdata", Hrdata, 32'hDEAD_BEEF);
    tick();
    check("rd_haddr2", Haddr2, 32'h8000_0010);
    check("rd_haddr1", Haddr1, 32'h8200_0004);
    check("rd_hwdata1", Hwdata1, 32'h1111_2222);
    check("rd_hwritereg", 32'(Hwritereg), 32'h0);

    // Window edge: last byte of region 2 is mapped, region 1 decode
    Htrans = HTRANS_IDLE; Haddr = 32'h82FF_FFFF;
    settle();
    check("edge_top_sel", 32'(tempselx), 32'h4);
    Haddr = 32'h8100_0000;
    settle();
    check("edge_r1_sel", 32'(tempselx), 32'h2);
    Haddr = 32'h7FFF_FFFF;
    settle();
    check("below_base_sel", 32'(tempselx), 32'h0);

    // Unmapped NONSEQ -> two-cycle ERROR
    Htrans = HTRANS_NONSEQ; Haddr = 32'h8300_0000;
    settle();
    check("unm_valid", 32'(valid), 32'h0);
    check("unm_sel", 32'(tempselx), 32'h0);
    check("unm_hresp0", 32'(Hresp), 32'h0);
    tick();
    Haddr = 32'h8000_0000;  // mapped, but valid must stay low during ERROR
    settle();
    check("err1_hresp", 32'(Hresp), 32'h1);
    check("err1_hready", 32'(Hreadyout), 32'h0);
    check("err1_valid", 32'(valid), 32'h0);
    check("err1_cnt", 32'(err_count), 32'h1);
    tick();
    Htrans = HTRANS_IDLE;
    settle();
    check("err2_hresp", 32'(Hresp), 32'h1);
    check("err2_hready", 32'(Hreadyout), 32'h1);
    check("err2_valid", 32'(valid), 32'h0);
    tick();
    check("post_hresp", 32'(Hresp), 32'h0);
    check("post_cnt", 32'(err_count), 32'h1);

    // Load known pipeline contents, then stall with Hreadyin=0
    Haddr = 32'h8100_0000; Hwdata = 32'hAAAA_5555;
    tick();
    Haddr = 32'h8100_0004; Hwdata = 32'hBBBB_CCCC;
    tick();
    Hreadyin = 1'b0; Htrans = HTRANS_NONSEQ;
    for (int i = 0; i < 3; i++) begin
      Haddr = (i == 1) ? 32'h9000_0000 : 32'h8000_0100 + 32'(i);
      Hwdata = 32'hF0F0_0000 + 32'(i);
      settle();
      check("stall_valid", 32'(valid), 32'h0);
      tick();
    end
    check("stall_haddr1", Haddr1, 32'h8100_0004);
    check("stall_haddr2", Haddr2, 32'h8100_0000);
    check("stall_hwdata1", Hwdata1, 32'hBBBB_CCCC);
    check("stall_hresp", 32'(Hresp), 32'h0);
    check("stall_cnt", 32'(err_count), 32'h1);

    // IDLE/BUSY never qualify, even with unmapped addresses
    Hreadyin = 1'b1; Htrans = HTRANS_IDLE; Haddr = 32'h8000_0020;
    settle();
    check("idle_valid", 32'(valid), 32'h0);
    Htrans = HTRANS_BUSY;
    settle();
    check("busy_valid", 32'(valid), 32'h0);
    Haddr = 32'h9000_0000;
    tick();
    check("busy_hresp", 32'(Hresp), 32'h0);
    check("busy_cnt", 32'(err_count), 32'h1);

    // Ready passthrough in OKAY
    Htrans = HTRANS_IDLE; Hreadyout_apb = 1'b0;
    settle();
    check("okay_ready_lo", 32'(Hreadyout), 32'h0);
    Hreadyout_apb = 1'b1;

    // Reset during ERR1 aborts the response
    Htrans = HTRANS_NONSEQ; Haddr = 32'hA000_0000; Hwrite = 1'b1; Hwdata = 32'h1234_5678;
    tick();
    check("pre_rst_hresp", 32'(Hresp), 32'h1);
    Hreset = 1'b1; Htrans = HTRANS_IDLE;
    tick();
    Hreset = 1'b0;
    settle();
    check("rst_err_hresp", 32'(Hresp), 32'h0);
    check("rst_err_cnt", 32'(err_count), 32'h0);
    check("rst_err_haddr1", Haddr1, 32'h0);
    check("rst_err_haddr2", Haddr2, 32'h0);
    check("rst_err_hwdata1", Hwdata1, 32'h0);
    check("rst_err_hwdata2", Hwdata2, 32'h0);
    check("rst_err_hwrite", 32'(Hwritereg), 32'h0);
    check("rst_err_ready", 32'(Hreadyout), 32'h1);
    tick();
    check("rst_err_next", 32'(Hresp), 32'h0);

    // 300 unmapped transfers saturate the counter
    for (int i = 0; i < 300; i++) begin
      Htrans = HTRANS_NONSEQ; Haddr = 32'h0000_1000;
      tick();
      Htrans = HTRANS_IDLE;
      tick();
      tick();
      if (i == 9) check("cnt_10", 32'(err_count), 32'd10);
    end
    check("cnt_sat", 32'(err_count), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
